// File: rtl/pulse_burst_sched.sv
// pulse_burst_sched: programmable burst scheduler for the pulse output stage.
// Holds shadow DELAY/PERIOD/WIDTH/COUNT settings written by the config port.
// On start, the settings are latched and a train of trigger strobes and pulse
// windows is emitted, followed by a one-cycle burst_done strobe.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_wr/addr/data    shadow register write (0 DELAY, 1 PERIOD, 2 WIDTH, 3 COUNT)
//   start, stop         begin burst (IDLE only) / abort immediately
//   busy                burst in progress (DELAY or RUN)
//   trigger             one-cycle strobe at the start of each period
//   pulse               high for the effective width at the start of each period
//   burst_done          one-cycle strobe after the last period of a finite burst
//   pulse_idx           pulses started in the current/last burst
module pulse_burst_sched #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             trigger,
  output logic             pulse,
  output logic             burst_done,
  output logic [CNT_W-1:0] pulse_idx
);

  typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] shd_delay_q, shd_delay_d;
  logic [CNT_W-1:0] shd_period_q, shd_period_d;
  logic [CNT_W-1:0] shd_width_q, shd_width_d;
  logic [CNT_W-1:0] shd_count_q, shd_count_d;

  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0] pulse_idx_q, pulse_idx_d;
  logic             burst_done_q, burst_done_d;

  logic [CNT_W-1:0] p_eff, w_eff;
  logic             run;

  assign run = (state_q == StRun);

  // Effective settings derived from the shadows at latch time.
  assign p_eff = (shd_period_q < CNT_W'(2)) ? CNT_W'(2) : shd_period_q;
  assign w_eff = (shd_width_q > (p_eff - CNT_W'(1))) ? (p_eff - CNT_W'(1)) : shd_width_q;

  always_comb begin
    state_d      = state_q;
    shd_delay_d  = shd_delay_q;
    shd_period_d = shd_period_q;
    shd_width_d  = shd_width_q;
    shd_count_d  = shd_count_q;
    p_d          = p_q;
    w_d          = w_q;
    count_d      = count_q;
    phase_d      = phase_q;
    delay_cnt_d  = delay_cnt_q;
    pulse_idx_d  = pulse_idx_q;
    burst_done_d = 1'b0;

    if (cfg_wr) begin
      unique case (cfg_addr)
        2'd0: shd_delay_d  = cfg_data;
        2'd1: shd_period_d = cfg_data;
        2'd2: shd_width_d  = cfg_data;
        2'd3: shd_count_d  = cfg_data;
      endcase
    end

    // pulse_idx doubles as the burst counter; it counts a pulse once its
    // trigger cycle has passed.
    if (trigger) begin
      pulse_idx_d = pulse_idx_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          // Latch from the registered shadows so a same-cycle write is not used.
          p_d         = p_eff;
          w_d         = w_eff;
          count_d     = shd_count_q;
          pulse_idx_d = '0;
          phase_d     = '0;
          if (shd_delay_q != '0) begin
            state_d     = StDelay;
            delay_cnt_d = shd_delay_q - CNT_W'(1);
          end else begin
            state_d = StRun;
          end
        end
      end
      StDelay: begin
        if (delay_cnt_q == '0) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          delay_cnt_d = delay_cnt_q - CNT_W'(1);
        end
      end
      StRun: begin
        if (phase_q == (p_q - CNT_W'(1))) begin
          if ((count_q != '0) && (pulse_idx_q == count_q)) begin
            state_d      = StIdle;
            burst_done_d = 1'b1;
          end else begin
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (stop) begin
      state_d      = StIdle;
      burst_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shd_delay_q  <= '0;
      shd_period_q <= CNT_W'(2);
      shd_width_q  <= CNT_W'(1);
      shd_count_q  <= CNT_W'(1);
      p_q          <= CNT_W'(2);
      w_q          <= CNT_W'(1);
      count_q      <= CNT_W'(1);
      phase_q      <= '0;
      delay_cnt_q  <= '0;
      pulse_idx_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shd_delay_q  <= shd_delay_d;
      shd_period_q <= shd_period_d;
      shd_width_q  <= shd_width_d;
      shd_count_q  <= shd_count_d;
      p_q          <= p_d;
      w_q          <= w_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      delay_cnt_q  <= delay_cnt_d;
      pulse_idx_q  <= pulse_idx_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign trigger    = run && (phase_q == '0);
  assign pulse      = run && (phase_q < w_q);
  assign burst_done = burst_done_q;
  assign pulse_idx  = pulse_idx_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Directed bench for pulse_burst_sched. Outputs are sampled 1ns after each
// rising edge and packed as {busy, trigger, pulse, burst_done}.
module tb_pulse_burst_sched;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [1:0]       cfg_addr = 2'd0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy, trigger, pulse, burst_done;
  logic [CNT_W-1:0] pulse_idx;

  int n_total = 0;
  int n_pass  = 0;

  pulse_burst_sched #(.CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .trigger    (trigger),
    .pulse      (pulse),
    .burst_done (burst_done),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the packed outputs of the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, busy, trigger, pulse, burst_done}, {28'd0, exp});
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [CNT_W-1:0] data);
    cfg_wr   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_outs", {28'd0, busy, trigger, pulse, burst_done}, 32'd0);
    check("reset_idx", pulse_idx, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Normal burst: D=0, P=4, W=2, COUNT=3.
    cfg_write(2'd1, 32'd4);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd3, 32'd3);
    do_start();
    for (int r = 0; r < 3; r++) begin
      step("t1_c0", 4'b1110);
      step("t1_c1", 4'b1010);
      step("t1_c2", 4'b1000);
      step("t1_c3", 4'b1000);
    end
    check("t1_idx", pulse_idx, 32'd3);
    step("t1_done", 4'b0001);
    step("t1_idle", 4'b0000);

    // Delay and clamping: D=5, PERIOD=1 -> P=2, WIDTH=9 -> W=1, COUNT=2.
    cfg_write(2'd0, 32'd5);
    cfg_write(2'd1, 32'd1);
    cfg_write(2'd2, 32'd9);
    cfg_write(2'd3, 32'd2);
    do_start();
    for (int c = 0; c < 5; c++) step("t2_delay", 4'b1000);
    step("t2_c5", 4'b1110);
    step("t2_c6", 4'b1000);
    step("t2_c7", 4'b1110);
    step("t2_c8", 4'b1000);
    check("t2_idx", pulse_idx, 32'd2);
    step("t2_done", 4'b0001);

    // Abort of a continuous burst: D=0, P=3, W=1, COUNT=0.
    cfg_write(2'd0, 32'd0);
    cfg_write(2'd1, 32'd3);
    cfg_write(2'd2, 32'd1);
    cfg_write(2'd3, 32'd0);
    do_start();
    for (int r = 0; r < 2; r++) begin
      step("t3_trig", 4'b1110);
      step("t3_gap", 4'b1000);
      step("t3_gap", 4'b1000);
    end
    step("t3_c6", 4'b1110);
    stop = 1'b1;
    step("t3_c7", 4'b1000);
    stop = 1'b0;
    step("t3_c8", 4'b0000);
    step("t3_c9", 4'b0000);
    check("t3_idx", pulse_idx, 32'd3);

    // start together with stop in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    step("t4_ss0", 4'b0000);
    step("t4_ss1", 4'b0000);

    // start during RUN is ignored: D=0, P=3, W=1, COUNT=2.
    cfg_write(2'd3, 32'd2);
    do_start();
    step("t4_c0", 4'b1110);
    start = 1'b1;
    step("t4_c1", 4'b1000);
    start = 1'b0;
    step("t4_c2", 4'b1000);
    step("t4_c3", 4'b1110);
    step("t4_c4", 4'b1000);
    step("t4_c5", 4'b1000);
    check("t4_idx", pulse_idx, 32'd2);
    step("t4_done", 4'b0001);

    // Shadow config: P=4, W=1, COUNT=2; PERIOD=6 written mid-burst.
    cfg_write(2'd1, 32'd4);
    do_start();
    cfg_wr   = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = 32'd6;
    step("t5_c0", 4'b1110);
    cfg_wr = 1'b0;
    for (int c = 1; c < 4; c++) step("t5_a_gap", 4'b1000);
    step("t5_c4", 4'b1110);
    for (int c = 5; c < 8; c++) step("t5_a_gap", 4'b1000);
    // Restart in the burst_done cycle, with a WIDTH=3 write in the same cycle.
    start    = 1'b1;
    cfg_wr   = 1'b1;
    cfg_addr = 2'd2;
    cfg_data = 32'd3;
    step("t5_done_a", 4'b0001);
    start  = 1'b0;
    cfg_wr = 1'b0;
    step("t5_b_c0", 4'b1110);
    for (int c = 1; c < 6; c++) step("t5_b_gap", 4'b1000);
    step("t5_b_c6", 4'b1110);
    for (int c = 7; c < 12; c++) step("t5_b_gap", 4'b1000);
    check("t5_idx", pulse_idx, 32'd2);
    step("t5_done_b", 4'b0001);

    // Asynchronous reset mid-pulse; shadows now P=6, W=3, COUNT=2.
    do_start();
    step("t6_c0", 4'b1110);
    check("t6_c1_pulse", {31'd0, pulse}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {28'd0, busy, trigger, pulse, burst_done}, 32'd0);
    check("t6_rst_idx", pulse_idx, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    do_start();
    step("t6_post_c0", 4'b1110);
    check("t6_post_idx", pulse_idx, 32'd1);
    step("t6_post_c1", 4'b1000);
    step("t6_post_done", 4'b0001);
    step("t6_post_idle", 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
